id_ex_operand_stage: RTL and testbench

Operand-resolution stage and ID/EX pipeline register of the RV32I pipelined core. It drives the GPR read addresses, takes the two read values, and overrides them with in-flight results forwarded from EX, MEM and WB. It detects true data hazards whose producer result is not yet available, and captures the resolved operands plus decode payload into the register that feeds EX. It owns the stall and bubble decisions between ID and EX.

---
 rtl/rv_pipe_pkg.sv | 34 +++
 rtl/operand_fwd_mux.sv | 35 +++
 rtl/id_ex_operand_stage.sv | 134 +++++++++++++
 tb/tb_id_ex_operand_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared types for the RV32I pipeline: widths, forward-source bundle, ID/EX payload.
package rv_pipe_pkg;
  localparam int XLEN     = 32;
  localparam int REGIDX_W = 5;
  localparam int CTRL_W   = 16;

  typedef enum logic [1:0] {FWD_GPR, FWD_EX, FWD_MEM, FWD_WB} fwd_sel_t;

  // One in-flight producer as seen by the operand stage
  typedef struct packed {
    logic                valid;
    logic                we;
    logic [REGIDX_W-1:0] rd;
    logic                rdy;
    logic [XLEN-1:0]     data;
  } fwd_src_t;

  // Contents of the ID/EX pipeline register
  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     imm;
    logic [XLEN-1:0]     rs1_data;
    logic [XLEN-1:0]     rs2_data;
    logic [REGIDX_W-1:0] rs1;
    logic [REGIDX_W-1:0] rs2;
    logic [REGIDX_W-1:0] rd;
    logic [CTRL_W-1:0]   ctrl;
  } id_ex_t;

  // A producer matches a source only if it really writes that (non-x0) register
  function automatic logic src_match(fwd_src_t s, logic [REGIDX_W-1:0] idx);
    return s.valid & s.we & (s.rd == idx) & (idx != '0);
  endfunction
endpackage

// File: rtl/operand_fwd_mux.sv
// Resolves one source operand: youngest matching producer wins, else GPR.
module operand_fwd_mux
  import rv_pipe_pkg::*;
(
  input  logic [REGIDX_W-1:0] idx,
  input  logic [XLEN-1:0]     gpr_data,
  input  fwd_src_t            ex_src,
  input  fwd_src_t            mem_src,
  input  fwd_src_t            wb_src,
  output logic [XLEN-1:0]     data,
  output fwd_sel_t            sel,
  output logic                hazard
);

  // Priority EX > MEM > WB > GPR; the deciding source alone sets the hazard
  always_comb begin
    sel    = FWD_GPR;
    data   = gpr_data;
    hazard = 1'b0;
    if (src_match(ex_src, idx)) begin
      sel    = FWD_EX;
      data   = ex_src.data;
      hazard = ~ex_src.rdy;
    end else if (src_match(mem_src, idx)) begin
      sel    = FWD_MEM;
      data   = mem_src.data;
      hazard = ~mem_src.rdy;
    end else if (src_match(wb_src, idx)) begin
      sel    = FWD_WB;
      data   = wb_src.data;
      hazard = ~wb_src.rdy;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// Operand resolution, hazard stall/bubble control and the ID/EX register.
module id_ex_operand_stage
  import rv_pipe_pkg::*;
#(
  parameter int XLEN     = rv_pipe_pkg::XLEN,
  parameter int REGIDX_W = rv_pipe_pkg::REGIDX_W,
  parameter int CTRL_W   = rv_pipe_pkg::CTRL_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [XLEN-1:0]     id_pc,
  input  logic [REGIDX_W-1:0] id_rs1,
  input  logic [REGIDX_W-1:0] id_rs2,
  input  logic [REGIDX_W-1:0] id_rd,
  input  logic                id_uses_rs1,
  input  logic                id_uses_rs2,
  input  logic [XLEN-1:0]     id_imm,
  input  logic [CTRL_W-1:0]   id_ctrl,
  output logic [REGIDX_W-1:0] gpr_rs1,
  output logic [REGIDX_W-1:0] gpr_rs2,
  input  logic [XLEN-1:0]     gpr_rs1_data,
  input  logic [XLEN-1:0]     gpr_rs2_data,
  input  logic                ex_fwd_valid,
  input  logic                ex_fwd_we,
  input  logic [REGIDX_W-1:0] ex_fwd_rd,
  input  logic                ex_fwd_rdy,
  input  logic [XLEN-1:0]     ex_fwd_data,
  input  logic                mem_fwd_valid,
  input  logic                mem_fwd_we,
  input  logic [REGIDX_W-1:0] mem_fwd_rd,
  input  logic                mem_fwd_rdy,
  input  logic [XLEN-1:0]     mem_fwd_data,
  input  logic                wb_fwd_valid,
  input  logic                wb_fwd_we,
  input  logic [REGIDX_W-1:0] wb_fwd_rd,
  input  logic                wb_fwd_rdy,
  input  logic [XLEN-1:0]     wb_fwd_data,
  input  logic                flush,
  input  logic                ex_ready,
  output logic                ex_valid,
  output logic [XLEN-1:0]     ex_pc,
  output logic [XLEN-1:0]     ex_imm,
  output logic [XLEN-1:0]     ex_rs1_data,
  output logic [XLEN-1:0]     ex_rs2_data,
  output logic [REGIDX_W-1:0] ex_rs1,
  output logic [REGIDX_W-1:0] ex_rs2,
  output logic [REGIDX_W-1:0] ex_rd,
  output logic [CTRL_W-1:0]   ex_ctrl,
  output logic [31:0]         stall_count
);

  localparam int NUM_OPS = 2;

  fwd_src_t                         ex_src, mem_src, wb_src;
  logic [NUM_OPS-1:0][REGIDX_W-1:0] rs_idx;
  logic [NUM_OPS-1:0][XLEN-1:0]     gpr_data;
  logic [NUM_OPS-1:0][XLEN-1:0]     rs_data;
  fwd_sel_t                         rs_sel [NUM_OPS];
  logic [NUM_OPS-1:0]               rs_haz;
  logic [NUM_OPS-1:0]               rs_uses;
  logic                             stall, load_en;
  id_ex_t                           ex_q;

  assign gpr_rs1  = id_rs1;
  assign gpr_rs2  = id_rs2;
  assign rs_idx   = {id_rs2, id_rs1};
  assign gpr_data = {gpr_rs2_data, gpr_rs1_data};
  assign rs_uses  = {id_uses_rs2, id_uses_rs1};

  assign ex_src  = '{valid: ex_fwd_valid,  we: ex_fwd_we,  rd: ex_fwd_rd,  rdy: ex_fwd_rdy,  data: ex_fwd_data};
  assign mem_src = '{valid: mem_fwd_valid, we: mem_fwd_we, rd: mem_fwd_rd, rdy: mem_fwd_rdy, data: mem_fwd_data};
  assign wb_src  = '{valid: wb_fwd_valid,  we: wb_fwd_we,  rd: wb_fwd_rd,  rdy: wb_fwd_rdy,  data: wb_fwd_data};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    operand_fwd_mux u_mux (
      .idx      (rs_idx[i]),
      .gpr_data (gpr_data[i]),
      .ex_src   (ex_src),
      .mem_src  (mem_src),
      .wb_src   (wb_src),
      .data     (rs_data[i]),
      .sel      (rs_sel[i]),
      .hazard   (rs_haz[i])
    );

    // Falling through to the register file must pass the GPR value unchanged
    a_gpr_pass: assert property (@(posedge clk) disable iff (!rst_n)
      (rs_sel[i] == FWD_GPR) |-> (rs_data[i] == gpr_data[i]));
  end

  // Only sources the instruction actually reads may hold it in ID
  assign stall   = id_valid & |(rs_uses & rs_haz);
  assign load_en = ex_ready | ~ex_valid;
  // flush always drains ID; otherwise ID moves only into a free, non-stalled register
  assign id_ready = flush | (load_en & ~stall);

  // ID/EX register: flush > hold > bubble > capture > empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_q     <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (load_en) begin
      if (stall) begin
        ex_valid <= 1'b0;
      end else if (id_valid) begin
        ex_valid <= 1'b1;
        ex_q     <= '{pc: id_pc, imm: id_imm, rs1_data: rs_data[0], rs2_data: rs_data[1],
                      rs1: id_rs1, rs2: id_rs2, rd: id_rd, ctrl: id_ctrl};
      end else begin
        ex_valid <= 1'b0;
      end
    end
  end

  // Saturating count of cycles lost to unresolved hazards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_count <= '0;
    else if (stall && !flush && stall_count != '1) stall_count <= stall_count + 32'd1;
  end

  assign ex_pc       = ex_q.pc;
  assign ex_imm      = ex_q.imm;
  assign ex_rs1_data = ex_q.rs1_data;
  assign ex_rs2_data = ex_q.rs2_data;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_rd       = ex_q.rd;
  assign ex_ctrl     = ex_q.ctrl;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench: stimulus pushes expected ID/EX payloads, a monitor pops them as EX consumes.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic [15:0] id_ctrl;
  logic [4:0]  gpr_rs1, gpr_rs2;
  logic [31:0] gpr_rs1_data, gpr_rs2_data;
  logic        ex_fwd_valid, ex_fwd_we, ex_fwd_rdy;
  logic        mem_fwd_valid, mem_fwd_we, mem_fwd_rdy;
  logic        wb_fwd_valid, wb_fwd_we, wb_fwd_rdy;
  logic [4:0]  ex_fwd_rd, mem_fwd_rd, wb_fwd_rd;
  logic [31:0] ex_fwd_data, mem_fwd_data, wb_fwd_data;
  logic        flush, ex_ready, ex_valid;
  logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data, stall_count;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [15:0] ex_ctrl;

  typedef struct {
    logic [31:0] pc, imm, d1, d2;
    logic [4:0]  rs1, rs2, rd;
    logic [15:0] ctrl;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_imm(id_imm), .id_ctrl(id_ctrl),
    .gpr_rs1(gpr_rs1), .gpr_rs2(gpr_rs2),
    .gpr_rs1_data(gpr_rs1_data), .gpr_rs2_data(gpr_rs2_data),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_we(ex_fwd_we), .ex_fwd_rd(ex_fwd_rd),
    .ex_fwd_rdy(ex_fwd_rdy), .ex_fwd_data(ex_fwd_data),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd),
    .mem_fwd_rdy(mem_fwd_rdy), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_valid(wb_fwd_valid), .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd),
    .wb_fwd_rdy(wb_fwd_rdy), .wb_fwd_data(wb_fwd_data),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .stall_count(stall_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                        input logic u1, u2, input logic [31:0] g1, g2);
    id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; gpr_rs1_data = g1; gpr_rs2_data = g2;
    id_imm = pc ^ 32'h0000_0F00; id_ctrl = pc[15:0] ^ 16'hA5A5;
  endtask

  // stage: 0=EX 1=MEM 2=WB
  task automatic set_fwd(input int stage, input logic v, we, input logic [4:0] rd,
                         input logic rdy, input logic [31:0] d);
    case (stage)
      0: begin ex_fwd_valid = v;  ex_fwd_we = we;  ex_fwd_rd = rd;  ex_fwd_rdy = rdy;  ex_fwd_data = d;  end
      1: begin mem_fwd_valid = v; mem_fwd_we = we; mem_fwd_rd = rd; mem_fwd_rdy = rdy; mem_fwd_data = d; end
      default: begin wb_fwd_valid = v; wb_fwd_we = we; wb_fwd_rd = rd; wb_fwd_rdy = rdy; wb_fwd_data = d; end
    endcase
  endtask

  task automatic clr_fwd();
    for (int s = 0; s < 3; s++) set_fwd(s, 1'b0, 1'b0, 5'd0, 1'b1, 32'd0);
  endtask

  // One cycle: check id_ready mid-cycle, record expected capture, advance past the edge
  task automatic step(input string name, input logic exp_rdy, input logic accept,
                      input logic [31:0] d1, input logic [31:0] d2);
    exp_t e;
    @(negedge clk);
    chk({name, "_id_ready"}, 32'(id_ready), 32'(exp_rdy));
    if (accept) begin
      e.pc = id_pc; e.imm = id_imm; e.d1 = d1; e.d2 = d2;
      e.rs1 = id_rs1; e.rs2 = id_rs2; e.rd = id_rd; e.ctrl = id_ctrl;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  // EX consumes the register whenever it is valid and ex_ready is high
  always @(negedge clk) begin
    if (rst_n && ex_valid && ex_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL mon_unexpected: got pc 0x%0h expected no instruction", ex_pc);
      end else begin
        me = sb.pop_front();
        if ({ex_pc, ex_imm, ex_rs1_data, ex_rs2_data, ex_rs1, ex_rs2, ex_rd, ex_ctrl} !==
            {me.pc, me.imm, me.d1, me.d2, me.rs1, me.rs2, me.rd, me.ctrl}) begin
          n_err++;
          $display("FAIL mon_payload: got pc=%0h imm=%0h d1=%0h d2=%0h rs=%0d/%0d rd=%0d ctrl=%0h expected pc=%0h imm=%0h d1=%0h d2=%0h rs=%0d/%0d rd=%0d ctrl=%0h",
                   ex_pc, ex_imm, ex_rs1_data, ex_rs2_data, ex_rs1, ex_rs2, ex_rd, ex_ctrl,
                   me.pc, me.imm, me.d1, me.d2, me.rs1, me.rs2, me.rd, me.ctrl);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    set_id(32'd0, 5'd7, 5'd9, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    id_valid = 1'b0;
    clr_fwd();
    #3;
    chk("rst_gpr_rs1", 32'(gpr_rs1), 32'd7);
    chk("rst_gpr_rs2", 32'(gpr_rs2), 32'd9);
    chk("rst_id_ready", 32'(id_ready), 32'd1);
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_pc", ex_pc, 32'd0);
    chk("rst_stall_count", stall_count, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // No forwarding: operands straight from the GPR file
    set_id(32'h100, 5'd3, 5'd4, 5'd1, 1'b1, 1'b1, 32'h11, 32'h22);
    step("basic", 1'b1, 1'b1, 32'h11, 32'h22);
    chk("basic_latency_valid", 32'(ex_valid), 32'd1);

    // Forwarding priority EX > MEM > WB over a stale GPR value
    set_fwd(0, 1'b1, 1'b1, 5'd5, 1'b1, 32'hA);
    set_fwd(1, 1'b1, 1'b1, 5'd5, 1'b1, 32'hB);
    set_fwd(2, 1'b1, 1'b1, 5'd5, 1'b1, 32'hC);
    set_id(32'h104, 5'd5, 5'd5, 5'd7, 1'b1, 1'b1, 32'h77, 32'h77);
    step("fwd_ex", 1'b1, 1'b1, 32'hA, 32'hA);
    ex_fwd_valid = 1'b0;
    set_id(32'h108, 5'd5, 5'd5, 5'd7, 1'b1, 1'b1, 32'h77, 32'h77);
    step("fwd_mem", 1'b1, 1'b1, 32'hB, 32'hB);
    mem_fwd_valid = 1'b0;
    set_id(32'h10C, 5'd5, 5'd5, 5'd7, 1'b1, 1'b1, 32'h77, 32'h77);
    step("fwd_wb", 1'b1, 1'b1, 32'hC, 32'hC);
    clr_fwd();

    // Load-use: load in EX stalls, then waits in MEM, then forwards from MEM
    set_fwd(0, 1'b1, 1'b1, 5'd6, 1'b0, 32'hDEAD);
    set_id(32'h110, 5'd6, 5'd2, 5'd8, 1'b1, 1'b1, 32'h5A, 32'h33);
    step("load_stall", 1'b0, 1'b0, 32'd0, 32'd0);
    chk("load_stall_count", stall_count, 32'd1);
    chk("load_bubble", 32'(ex_valid), 32'd0);
    clr_fwd();
    set_fwd(1, 1'b1, 1'b1, 5'd6, 1'b0, 32'h0);
    step("mem_wait", 1'b0, 1'b0, 32'd0, 32'd0);
    chk("mem_wait_count", stall_count, 32'd2);
    chk("mem_wait_bubble", 32'(ex_valid), 32'd0);
    set_fwd(1, 1'b1, 1'b1, 5'd6, 1'b1, 32'h55);
    step("load_fwd", 1'b1, 1'b1, 32'h55, 32'h33);
    chk("load_fwd_count", stall_count, 32'd2);
    clr_fwd();

    // Unused source never stalls; its value is still the mux result
    set_fwd(0, 1'b1, 1'b1, 5'd6, 1'b0, 32'h66);
    set_id(32'h120, 5'd1, 5'd6, 5'd9, 1'b1, 1'b0, 32'h10, 32'h44);
    step("unused_rs2", 1'b1, 1'b1, 32'h10, 32'h66);
    chk("unused_rs2_count", stall_count, 32'd2);

    // A producer writing x0 is never forwarded
    set_fwd(0, 1'b1, 1'b1, 5'd0, 1'b1, 32'h99);
    set_id(32'h124, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 32'h0, 32'h0);
    step("x0_src", 1'b1, 1'b1, 32'h0, 32'h0);
    clr_fwd();

    // Back-pressure holds the register, stall under hold, then flush wins
    set_id(32'h130, 5'd3, 5'd4, 5'd11, 1'b1, 1'b1, 32'h11, 32'h22);
    step("hold_src", 1'b1, 1'b1, 32'h11, 32'h22);
    ex_ready = 1'b0;
    set_id(32'h134, 5'd1, 5'd2, 5'd12, 1'b1, 1'b1, 32'h1, 32'h2);
    step("held", 1'b0, 1'b0, 32'd0, 32'd0);
    chk("held_valid", 32'(ex_valid), 32'd1);
    chk("held_pc", ex_pc, 32'h130);
    chk("held_rs1_data", ex_rs1_data, 32'h11);
    set_fwd(0, 1'b1, 1'b1, 5'd6, 1'b0, 32'h0);
    set_id(32'h138, 5'd6, 5'd2, 5'd12, 1'b1, 1'b1, 32'h1, 32'h2);
    step("held_stall", 1'b0, 1'b0, 32'd0, 32'd0);
    chk("held_stall_valid", 32'(ex_valid), 32'd1);
    chk("held_stall_pc", ex_pc, 32'h130);
    chk("held_stall_count", stall_count, 32'd3);
    flush = 1'b1;
    void'(sb.pop_front());
    step("flush", 1'b1, 1'b0, 32'd0, 32'd0);
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_count", stall_count, 32'd3);
    flush = 1'b0; ex_ready = 1'b1; id_valid = 1'b0;
    clr_fwd();
    step("idle", 1'b1, 1'b0, 32'd0, 32'd0);

    // Asynchronous reset in the middle of a held stall
    set_id(32'h140, 5'd3, 5'd4, 5'd13, 1'b1, 1'b1, 32'h31, 32'h32);
    step("pre_rst", 1'b1, 1'b1, 32'h31, 32'h32);
    ex_ready = 1'b0;
    set_fwd(0, 1'b1, 1'b1, 5'd6, 1'b0, 32'h0);
    set_id(32'h144, 5'd6, 5'd4, 5'd14, 1'b1, 1'b1, 32'h0, 32'h0);
    step("rst_stall", 1'b0, 1'b0, 32'd0, 32'd0);
    chk("rst_stall_count", stall_count, 32'd4);
    chk("rst_stall_valid", 32'(ex_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    void'(sb.pop_front());
    chk("arst_valid", 32'(ex_valid), 32'd0);
    chk("arst_pc", ex_pc, 32'd0);
    chk("arst_imm", ex_imm, 32'd0);
    chk("arst_rs1_data", ex_rs1_data, 32'd0);
    chk("arst_rs2_data", ex_rs2_data, 32'd0);
    chk("arst_rd", 32'(ex_rd), 32'd0);
    chk("arst_ctrl", 32'(ex_ctrl), 32'd0);
    chk("arst_count", stall_count, 32'd0);
    id_valid = 1'b0; ex_ready = 1'b1;
    clr_fwd();
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
